// File: rtl/audio_mixer_pkg.sv
// Shared types and helpers for the N-channel audio mixer.
// Optional DC blocking is enabled with AUDIO_MIXER_DC_BLOCK_EN.
package audio_mixer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_SAT   = 3'd2,
        ST_DCB   = 3'd3,
        ST_OUT   = 3'd4
    } mix_state_t;

    localparam int DCB_POLE_SHIFT = 10;

    function automatic int acc_width(
        input int in_w,
        input int gain_w,
        input int num_ch
    );
        return in_w + gain_w + $clog2(num_ch) + 1;
    endfunction

    function automatic int gain_unity(input int gain_w);
        return 1 << (gain_w - 1);
    endfunction

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic logic is_clipped(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/audio_mixer_dc_block.sv
// First-order DC blocker applied to the saturated mix.
// Used only when AUDIO_MIXER_DC_BLOCK_EN is defined.
module audio_mixer_dc_block #(
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic signed [OUT_WIDTH-1:0] x,
    output logic signed [OUT_WIDTH-1:0] y,
    output logic                        clip
);
    import audio_mixer_pkg::*;

    localparam int W = OUT_WIDTH + 2;

    logic signed [OUT_WIDTH-1:0] x_prev;
    logic signed [W-1:0]         sum;
    logic signed [63:0]          wide;

    // y doubles as y_prev: it holds the last filtered output
    always_comb begin
        sum = W'(x) - W'(x_prev) + W'(y)
            - W'(y >>> DCB_POLE_SHIFT);
        wide = 64'(sum);
        clip = en && is_clipped(wide, OUT_WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev <= '0;
            y      <= '0;
        end else if (en) begin
            x_prev <= x;
            y      <= OUT_WIDTH'(saturate(wide, OUT_WIDTH));
        end
    end

endmodule

// File: rtl/audio_mixer.sv
// Serial MAC audio mixer with per-channel gain, mute and saturation.
// Define AUDIO_MIXER_DC_BLOCK_EN to add a DC-blocking stage.
module audio_mixer #(
    parameter int                NUM_CH     = 4,
    parameter int                IN_WIDTH   = 16,
    parameter int                OUT_WIDTH  = 16,
    parameter int                GAIN_WIDTH = 8,
    parameter logic [NUM_CH-1:0] CH_SIGNED  = '0,
    localparam int GCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_strobe_i,
    input  logic [NUM_CH*IN_WIDTH-1:0]   ch_data_i,
    input  logic [NUM_CH-1:0]            mute_i,
    input  logic                         gain_wr_i,
    input  logic [GCH_W-1:0]             gain_ch_i,
    input  logic [GAIN_WIDTH-1:0]        gain_i,
    input  logic                         clip_clr_i,
    output logic signed [OUT_WIDTH-1:0]  audio_o,
    output logic                         valid_o,
    output logic                         busy_o,
    output logic                         clip_o,
    output logic                         overrun_o
);
    import audio_mixer_pkg::*;

    localparam int IDX_W  = GCH_W;
    localparam int ACC_W  = acc_width(IN_WIDTH, GAIN_WIDTH, NUM_CH);
    localparam int PROD_W = IN_WIDTH + GAIN_WIDTH + 1;
    localparam int SH     = OUT_WIDTH - IN_WIDTH;
    localparam int LSH    = (SH > 0) ? SH : 0;
    localparam int RSH    = (SH < 0) ? -SH : 0;
    localparam logic [GAIN_WIDTH-1:0] UNITY =
        GAIN_WIDTH'(gain_unity(GAIN_WIDTH));
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    mix_state_t state;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;

    logic [GAIN_WIDTH-1:0] gain      [NUM_CH];
    logic [GAIN_WIDTH-1:0] snap_gain [NUM_CH];
    logic [IN_WIDTH-1:0]   snap_data [NUM_CH];
    logic [NUM_CH-1:0]     snap_mute;

    logic [IN_WIDTH-1:0]         cur_raw;
    logic signed [PROD_W-1:0]    ext_s;
    logic signed [PROD_W-1:0]    ext_g;
    logic signed [PROD_W-1:0]    prod;
    logic signed [63:0]          aligned;
    logic signed [OUT_WIDTH-1:0] sat_val;
    logic signed [OUT_WIDTH-1:0] sat_q;
    logic signed [OUT_WIDTH-1:0] out_val;
    logic                        sat_clip;
    logic                        dcb_clip;
    logic                        clip_set;
    logic                        ovr_set;

`ifdef AUDIO_MIXER_DC_BLOCK_EN
    localparam mix_state_t POST_SAT = ST_DCB;

    audio_mixer_dc_block #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_dc_block (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_DCB),
        .x     (sat_q),
        .y     (out_val),
        .clip  (dcb_clip)
    );
`else
    localparam mix_state_t POST_SAT = ST_OUT;

    assign out_val  = sat_q;
    assign dcb_clip = 1'b0;
`endif

    // Offset-binary channels become two's complement by flipping the MSB
    always_comb begin
        cur_raw = snap_data[idx];
        if (!CH_SIGNED[idx]) begin
            cur_raw[IN_WIDTH-1] = ~cur_raw[IN_WIDTH-1];
        end
        ext_s = PROD_W'($signed(cur_raw));
        ext_g = $signed(PROD_W'(snap_gain[idx]));
        prod  = snap_mute[idx] ? '0 : ext_s * ext_g;
    end

    always_comb begin
        aligned  = 64'(acc);
        aligned  = aligned >>> (GAIN_WIDTH - 1);
        aligned  = (aligned <<< LSH) >>> RSH;
        sat_val  = OUT_WIDTH'(saturate(aligned, OUT_WIDTH));
        sat_clip = is_clipped(aligned, OUT_WIDTH);
    end

    assign busy_o   = (state != ST_IDLE);
    assign clip_set = ((state == ST_SAT) && sat_clip) || dcb_clip;
    assign ovr_set  = sample_strobe_i && (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                gain[i] <= UNITY;
            end
        end else if (gain_wr_i && (int'(gain_ch_i) < NUM_CH)) begin
            gain[gain_ch_i] <= gain_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (clip_set) begin
                clip_o <= 1'b1;
            end else if (clip_clr_i) begin
                clip_o <= 1'b0;
            end
            if (ovr_set) begin
                overrun_o <= 1'b1;
            end else if (clip_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            acc       <= '0;
            sat_q     <= '0;
            audio_o   <= '0;
            valid_o   <= 1'b0;
            snap_mute <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_data[i] <= '0;
                snap_gain[i] <= '0;
            end
        end else begin
            valid_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (sample_strobe_i) begin
                        state     <= ST_ACCUM;
                        acc       <= '0;
                        idx       <= '0;
                        snap_mute <= mute_i;
                        for (int i = 0; i < NUM_CH; i++) begin
                            snap_data[i] <=
                                ch_data_i[i*IN_WIDTH +: IN_WIDTH];
                            snap_gain[i] <= gain[i];
                        end
                    end
                end
                ST_ACCUM: begin
                    acc <= acc + ACC_W'(prod);
                    if (idx == LAST) begin
                        state <= ST_SAT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_SAT: begin
                    sat_q <= sat_val;
                    state <= POST_SAT;
                end
                ST_DCB: begin
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    audio_o <= out_val;
                    valid_o <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
